// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the unified instruction/data RAM between three requesters:
//   CPU data port (D), CPU instruction fetch (I) and debug/loader (G).
//   One access is in flight at a time. Base priority is D > I > G. I or G is
//   promoted above D once it has lost STARVE_MAX consecutive arbitrations
//   (I wins if both are promoted).
//
//   Optional feature macro: MEM_ARB_PERF_EN adds 32-bit wrapping counters
//   perf_i_cnt / perf_d_cnt / perf_g_cnt (acks per port) and
//   perf_conflict_cnt (IDLE arbitrations with two or more requests).
//
//   Ports
//     clk, reset               system clock, async active-low reset
//     i_req/i_addr             fetch request (read only)  -> i_ack, i_valid
//     d_req/d_we/d_be/d_addr/d_wdata  data request        -> d_ack, d_valid
//     g_req/g_we/g_addr/g_wdata       debug request       -> g_ack, g_valid
//     rdata                    shared read data, qualified by *_valid
//     mem_en/mem_we/mem_addr/mem_wdata/mem_rdata  RAM side
//
//   state  | meaning
//   IDLE   | arbitrate, latch winner and its access
//   ISSUE  | winner ack + mem_en, load latency counter
//   WAIT   | count down MEM_LAT cycles, capture mem_rdata on the last
//   RESP   | winner valid pulse
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic              i_valid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic              d_valid,
    input  logic              g_req,
    input  logic              g_we,
    input  logic [ADDR_W-1:0] g_addr,
    input  logic [DATA_W-1:0] g_wdata,
    output logic              g_ack,
    output logic              g_valid,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]       perf_i_cnt,
    output logic [31:0]       perf_d_cnt,
    output logic [31:0]       perf_g_cnt,
    output logic [31:0]       perf_conflict_cnt
`endif
);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;
    typedef enum logic [1:0] {PORT_NONE, PORT_I, PORT_D, PORT_G} port_t;

    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);
    localparam logic [2:0] LAT_INIT   = 3'(MEM_LAT);

    state_t     r_state;
    port_t      r_port;
    logic       r_write;
    logic [2:0] r_lat;
    logic [7:0] r_starve_i;
    logic [7:0] r_starve_g;

    port_t      w_win;
    logic       w_i_starved;
    logic       w_g_starved;
    logic [7:0] w_starve_i_inc;
    logic [7:0] w_starve_g_inc;

    assign w_i_starved    = i_req && (r_starve_i == STARVE_LIM);
    assign w_g_starved    = g_req && (r_starve_g == STARVE_LIM);
    assign w_starve_i_inc = (r_starve_i == STARVE_LIM) ? STARVE_LIM : r_starve_i + 8'd1;
    assign w_starve_g_inc = (r_starve_g == STARVE_LIM) ? STARVE_LIM : r_starve_g + 8'd1;

    always_comb begin
        w_win = PORT_NONE;
        if (w_i_starved)      w_win = PORT_I;
        else if (w_g_starved) w_win = PORT_G;
        else if (d_req)       w_win = PORT_D;
        else if (i_req)       w_win = PORT_I;
        else if (g_req)       w_win = PORT_G;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_port     <= PORT_NONE;
            r_write    <= 1'b0;
            r_lat      <= 3'd0;
            r_starve_i <= 8'd0;
            r_starve_g <= 8'd0;
            i_ack      <= 1'b0;
            i_valid    <= 1'b0;
            d_ack      <= 1'b0;
            d_valid    <= 1'b0;
            g_ack      <= 1'b0;
            g_valid    <= 1'b0;
            rdata      <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 4'h0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            // pulses default low; set only on the edge entering ISSUE/RESP
            i_ack   <= 1'b0;
            d_ack   <= 1'b0;
            g_ack   <= 1'b0;
            i_valid <= 1'b0;
            d_valid <= 1'b0;
            g_valid <= 1'b0;
            mem_en  <= 1'b0;
            mem_we  <= 4'h0;
            case (r_state)
                ST_IDLE: begin
                    r_starve_i <= (i_req && (w_win != PORT_I)) ? w_starve_i_inc : 8'd0;
                    r_starve_g <= (g_req && (w_win != PORT_G)) ? w_starve_g_inc : 8'd0;
                    r_port     <= w_win;
                    case (w_win)
                        PORT_I: begin
                            i_ack     <= 1'b1;
                            mem_en    <= 1'b1;
                            mem_addr  <= i_addr;
                            mem_wdata <= '0;
                            r_write   <= 1'b0;
                            r_state   <= ST_ISSUE;
                        end
                        PORT_D: begin
                            d_ack     <= 1'b1;
                            mem_en    <= 1'b1;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                            mem_we    <= d_we ? d_be : 4'h0;
                            r_write   <= d_we;
                            r_state   <= ST_ISSUE;
                        end
                        PORT_G: begin
                            g_ack     <= 1'b1;
                            mem_en    <= 1'b1;
                            mem_addr  <= g_addr;
                            mem_wdata <= g_wdata;
                            mem_we    <= g_we ? 4'hF : 4'h0;
                            r_write   <= g_we;
                            r_state   <= ST_ISSUE;
                        end
                        default: ;
                    endcase
                end
                ST_ISSUE: begin
                    r_lat   <= LAT_INIT;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (r_lat == 3'd1) begin
                        // writes keep the last read word on rdata
                        if (!r_write) rdata <= mem_rdata;
                        i_valid <= (r_port == PORT_I);
                        d_valid <= (r_port == PORT_D);
                        g_valid <= (r_port == PORT_G);
                        r_state <= ST_RESP;
                    end else begin
                        r_lat <= r_lat - 3'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef MEM_ARB_PERF_EN
    logic [1:0] w_nreq;
    assign w_nreq = {1'b0, i_req} + {1'b0, d_req} + {1'b0, g_req};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_i_cnt        <= 32'd0;
            perf_d_cnt        <= 32'd0;
            perf_g_cnt        <= 32'd0;
            perf_conflict_cnt <= 32'd0;
        end else if (r_state == ST_IDLE) begin
            if (w_nreq >= 2'd2) perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
            case (w_win)
                PORT_I:  perf_i_cnt <= perf_i_cnt + 32'd1;
                PORT_D:  perf_d_cnt <= perf_d_cnt + 32'd1;
                PORT_G:  perf_g_cnt <= perf_g_cnt + 32'd1;
                default: ;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
    localparam int LAT_A = 1, SM_A = 8, LAT_B = 4, SM_B = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        i_req = 1'b0, d_req = 1'b0, g_req = 1'b0;
    logic        d_we = 1'b0, g_we = 1'b0;
    logic [3:0]  d_be = 4'h0;
    logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0, g_addr = 0, g_wdata = 0;
    logic [31:0] mem_rdata;

    logic        a_i_ack, a_i_valid, a_d_ack, a_d_valid, a_g_ack, a_g_valid, a_mem_en;
    logic        b_i_ack, b_i_valid, b_d_ack, b_d_valid, b_g_ack, b_g_valid, b_mem_en;
    logic [3:0]  a_mem_we, b_mem_we;
    logic [31:0] a_rdata, a_mem_addr, a_mem_wdata, b_rdata, b_mem_addr, b_mem_wdata;
`ifdef MEM_ARB_PERF_EN
    logic [31:0] a_perf_i, a_perf_d, a_perf_g, a_perf_c;
    logic [31:0] b_perf_i, b_perf_d, b_perf_g, b_perf_c;
`endif

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT_A), .STARVE_MAX(SM_A)) dut_a (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(a_i_ack), .i_valid(a_i_valid),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(a_d_ack), .d_valid(a_d_valid),
        .g_req(g_req), .g_we(g_we), .g_addr(g_addr), .g_wdata(g_wdata),
        .g_ack(a_g_ack), .g_valid(a_g_valid),
        .rdata(a_rdata), .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_rdata(mem_rdata)
`ifdef MEM_ARB_PERF_EN
        , .perf_i_cnt(a_perf_i), .perf_d_cnt(a_perf_d), .perf_g_cnt(a_perf_g),
        .perf_conflict_cnt(a_perf_c)
`endif
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT_B), .STARVE_MAX(SM_B)) dut_b (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(b_i_ack), .i_valid(b_i_valid),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(b_d_ack), .d_valid(b_d_valid),
        .g_req(g_req), .g_we(g_we), .g_addr(g_addr), .g_wdata(g_wdata),
        .g_ack(b_g_ack), .g_valid(b_g_valid),
        .rdata(b_rdata), .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(mem_rdata)
`ifdef MEM_ARB_PERF_EN
        , .perf_i_cnt(b_perf_i), .perf_d_cnt(b_perf_d), .perf_g_cnt(b_perf_g),
        .perf_conflict_cnt(b_perf_c)
`endif
    );

    // observed instance: 0 = A (lat 1, starve 8), 1 = B (lat 4, starve 2)
    bit          sel = 1'b0;
    logic [2:0]  ack3, val3;      // {I, D, G}
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic        mem_en;
    logic [3:0]  mem_we;
    assign ack3      = sel ? {b_i_ack, b_d_ack, b_g_ack} : {a_i_ack, a_d_ack, a_g_ack};
    assign val3      = sel ? {b_i_valid, b_d_valid, b_g_valid} : {a_i_valid, a_d_valid, a_g_valid};
    assign rdata     = sel ? b_rdata : a_rdata;
    assign mem_en    = sel ? b_mem_en : a_mem_en;
    assign mem_we    = sel ? b_mem_we : a_mem_we;
    assign mem_addr  = sel ? b_mem_addr : a_mem_addr;
    assign mem_wdata = sel ? b_mem_wdata : a_mem_wdata;

    int n_chk = 0, n_pass = 0;
    int lat = LAT_A, smax = SM_A;
    int st_i = 0, st_g = 0;          // consecutive losses of I and G
    logic [31:0] prev_rdata = 0;
    int wins[$];

    // RAM environment (written by the DUT) and expected memory (written by intent)
    bit [31:0] ram [bit [31:0]];
    bit [31:0] exp_mem [bit [31:0]];
    logic [31:0] rd_word = 0;
    int ram_age = 0;

    function automatic logic [31:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : 32'h0;
    endfunction
    function automatic logic [31:0] exp_rd(input logic [31:0] a);
        return exp_mem.exists(a) ? exp_mem[a] : 32'h0;
    endfunction

    // read data only appears on mem_rdata exactly lat cycles after mem_en
    assign mem_rdata = (ram_age == lat) ? rd_word : 32'hA5A5_5A5A;

    always @(posedge clk) begin : ram_model
        logic [31:0] w;
        if (mem_en) begin
            w = ram_rd(mem_addr);
            if (mem_we != 4'h0) begin
                for (int b = 0; b < 4; b++)
                    if (mem_we[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
                ram[mem_addr] = w;
            end
            rd_word <= w;
            ram_age <= 1;
        end else if (ram_age > 0 && ram_age < 15) begin
            ram_age <= ram_age + 1;
        end
    end

    function automatic int model_pick(input logic [2:0] m);
        if (m[2] && st_i >= smax) return 0;
        if (m[0] && st_g >= smax) return 2;
        if (m[1]) return 1;
        if (m[2]) return 0;
        return 2;
    endfunction

    task automatic model_after(input logic [2:0] m, input int w);
        st_i = (m[2] && w != 0) ? ((st_i + 1 > smax) ? smax : st_i + 1) : 0;
        st_g = (m[0] && w != 2) ? ((st_g + 1 > smax) ? smax : st_g + 1) : 0;
    endtask

    task automatic use_dut(input bit s);
        sel  = s;
        lat  = s ? LAT_B : LAT_A;
        smax = s ? SM_B : SM_A;
    endtask

    task automatic clr_req();
        i_req = 0; d_req = 0; g_req = 0;
        d_we = $urandom; g_we = $urandom; d_be = 4'($urandom);
        i_addr = $urandom; d_addr = $urandom; g_addr = $urandom;
        d_wdata = $urandom; g_wdata = $urandom;
    endtask

    task automatic set_req(input int p, input bit we, input logic [3:0] be,
                           input logic [31:0] a, input logic [31:0] wd);
        case (p)
            0: begin i_req = 1; i_addr = a; end
            1: begin d_req = 1; d_we = we; d_be = be; d_addr = a; d_wdata = wd; end
            default: begin g_req = 1; g_we = we; g_addr = a; g_wdata = wd; end
        endcase
    endtask

    task automatic do_reset();
        @(negedge clk);
        clr_req();
        reset = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1;
        st_i = 0; st_g = 0; prev_rdata = 0;
    endtask

    // Single access started at the negedge of an IDLE cycle; returns at the next IDLE negedge.
    task automatic access(input int p, input bit we, input logic [3:0] be,
                          input logic [31:0] a, input logic [31:0] wd, input string nm);
        logic [2:0]  oh;
        logic [3:0]  exp_we;
        logic [31:0] exp_r, w;
        oh     = 3'b100 >> p;
        exp_we = (p == 1 && we) ? be : (p == 2 && we) ? 4'hF : 4'h0;
        set_req(p, we, be, a, wd);
        @(negedge clk);
        n_chk++; if (ack3 !== oh) $display("FAIL %s ack: got %b want %b", nm, ack3, oh); else n_pass++;
        n_chk++; if (mem_en !== 1'b1) $display("FAIL %s mem_en: got %b want 1", nm, mem_en); else n_pass++;
        n_chk++; if (mem_addr !== a) $display("FAIL %s mem_addr: got %h want %h", nm, mem_addr, a); else n_pass++;
        n_chk++; if (mem_we !== exp_we) $display("FAIL %s mem_we: got %b want %b", nm, mem_we, exp_we); else n_pass++;
        if (exp_we != 4'h0) begin
            n_chk++; if (mem_wdata !== wd) $display("FAIL %s mem_wdata: got %h want %h", nm, mem_wdata, wd); else n_pass++;
        end
        clr_req();
        st_i = 0; st_g = 0;
        if (exp_we != 4'h0) begin
            w = exp_rd(a);
            for (int b = 0; b < 4; b++) if (exp_we[b]) w[8*b +: 8] = wd[8*b +: 8];
            exp_mem[a] = w;
        end
        exp_r = we ? prev_rdata : exp_rd(a);
        for (int c = 0; c < lat; c++) begin
            @(negedge clk);
            n_chk++;
            if ({ack3, val3, mem_en} !== 7'b0)
                $display("FAIL %s quiet_wait: got ack %b valid %b en %b want all 0", nm, ack3, val3, mem_en);
            else n_pass++;
        end
        @(negedge clk);
        n_chk++; if (val3 !== oh) $display("FAIL %s valid: got %b want %b", nm, val3, oh); else n_pass++;
        n_chk++; if (rdata !== exp_r) $display("FAIL %s rdata: got %h want %h", nm, rdata, exp_r); else n_pass++;
        prev_rdata = exp_r;
        @(negedge clk);
    endtask

    // Arbitration rounds: requests held only through the IDLE cycle, all reads.
    task automatic arb_rounds(input int n, input bit rnd, input logic [2:0] fixed_m, input string nm);
        logic [2:0]  m, oh;
        logic [31:0] ad [3];
        int w;
        wins.delete();
        for (int r = 0; r < n; r++) begin
            m = rnd ? 3'($urandom_range(1, 7)) : fixed_m;
            for (int p = 0; p < 3; p++) begin
                ad[p] = 32'h1000_0000 + 32'($urandom_range(0, 15) * 4);
                if (m[2-p]) set_req(p, 1'b0, 4'h0, ad[p], 32'h0);
            end
            w  = model_pick(m);
            oh = 3'b100 >> w;
            @(negedge clk);
            n_chk++; if (ack3 !== oh) $display("FAIL %s[%0d] grant: got %b want %b (req %b)", nm, r, ack3, oh, m); else n_pass++;
            model_after(m, w);
            wins.push_back(w);
            clr_req();
            repeat (lat) @(negedge clk);
            @(negedge clk);
            n_chk++; if (val3 !== oh) $display("FAIL %s[%0d] valid: got %b want %b", nm, r, val3, oh); else n_pass++;
            n_chk++; if (rdata !== exp_rd(ad[w])) $display("FAIL %s[%0d] rdata: got %h want %h", nm, r, rdata, exp_rd(ad[w])); else n_pass++;
            prev_rdata = exp_rd(ad[w]);
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        #1;
        for (int s = 0; s < 2; s++) begin
            use_dut(s[0]);
            #1;
            n_chk++;
            if ({ack3, val3, mem_en, mem_we} !== 11'b0 || rdata !== 0 || mem_addr !== 0 || mem_wdata !== 0)
                $display("FAIL reset_outputs[%0d]: got ack %b val %b en %b we %b rdata %h addr %h wdata %h want all 0",
                         s, ack3, val3, mem_en, mem_we, rdata, mem_addr, mem_wdata);
            else n_pass++;
        end
        use_dut(0);
        @(negedge clk);
        reset = 1;
    endtask

    task automatic test_fetch();
        use_dut(0);
        ram[32'h0040_0000] = 32'h3C01_0000;
        exp_mem[32'h0040_0000] = 32'h3C01_0000;
        access(0, 1'b0, 4'h0, 32'h0040_0000, 32'h0, "fetch");
    endtask

    task automatic test_byte_write();
        use_dut(0);
        ram[32'h1001_0004] = 32'h1234_5678;
        exp_mem[32'h1001_0004] = 32'h1234_5678;
        access(1, 1'b1, 4'b0011, 32'h1001_0004, 32'hDEAD_BEEF, "d_write");
        access(1, 1'b0, 4'h0, 32'h1001_0004, 32'h0, "d_readback");
        n_chk++; if (rdata !== 32'h1234_BEEF) $display("FAIL byte_merge: got %h want 1234beef", rdata); else n_pass++;
        access(2, 1'b1, 4'h0, 32'h1001_0008, 32'h0BAD_F00D, "g_write");
        access(2, 1'b0, 4'h0, 32'h1001_0008, 32'h0, "g_readback");
    endtask

    task automatic test_starve_hold();
        int n_d;
        use_dut(0);
        do_reset();
        arb_rounds(18, 1'b0, 3'b110, "starve_id");
        n_d = 0;
        for (int k = 0; k < 8; k++) if (wins[k] == 1) n_d++;
        n_chk++; if (n_d != 8) $display("FAIL starve_first8: got %0d D grants want 8", n_d); else n_pass++;
        n_chk++; if (wins[8] != 0) $display("FAIL starve_9th: got port %0d want 0 (I)", wins[8]); else n_pass++;
        n_chk++; if (wins[9] != 1) $display("FAIL starve_clear: got port %0d want 1 (D)", wins[9]); else n_pass++;
        n_chk++; if (wins[17] != 0) $display("FAIL starve_18th: got port %0d want 0 (I)", wins[17]); else n_pass++;
    endtask

    task automatic test_three_way();
        int last;
        use_dut(1);
        do_reset();
        arb_rounds(12, 1'b0, 3'b111, "three_way");
        n_chk++; if (wins[0] != 1 || wins[1] != 1 || wins[2] != 0)
            $display("FAIL three_way_head: got %0d,%0d,%0d want 1,1,0", wins[0], wins[1], wins[2]); else n_pass++;
        last = -1;
        for (int k = 0; k < 12; k++) if (wins[k] == 2) begin
            n_chk++; if (k - last > SM_B + 2) $display("FAIL g_wait at %0d: got gap %0d want <= %0d", k, k - last, SM_B + 2); else n_pass++;
            last = k;
        end
        n_chk++; if (11 - last > SM_B + 2) $display("FAIL g_wait_tail: got gap %0d want <= %0d", 11 - last, SM_B + 2); else n_pass++;
    endtask

    task automatic test_reset_wait();
        use_dut(1);
        do_reset();
        ram[32'h2000_0040] = 32'hCAFE_F00D;
        exp_mem[32'h2000_0040] = 32'hCAFE_F00D;
        access(0, 1'b0, 4'h0, 32'h2000_0040, 32'h0, "pre_abort");
        set_req(0, 1'b0, 4'h0, 32'h2000_0040, 32'h0);
        @(negedge clk);
        clr_req();
        @(negedge clk);
        @(negedge clk);
        reset = 0;
        #1;
        n_chk++;
        if ({ack3, val3, mem_en, mem_we} !== 11'b0 || rdata !== 0 || mem_addr !== 0 || mem_wdata !== 0)
            $display("FAIL abort_outputs: got ack %b val %b en %b rdata %h addr %h want all 0",
                     ack3, val3, mem_en, rdata, mem_addr);
        else n_pass++;
        @(negedge clk);
        reset = 1;
        st_i = 0; st_g = 0; prev_rdata = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            n_chk++; if ({ack3, val3} !== 6'b0) $display("FAIL abort_quiet[%0d]: got ack %b val %b want 0", c, ack3, val3); else n_pass++;
        end
        access(0, 1'b0, 4'h0, 32'h2000_0040, 32'h0, "post_abort");
    endtask

    task automatic test_random();
        int p;
        for (int s = 0; s < 2; s++) begin
            use_dut(s[0]);
            do_reset();
            for (int k = 0; k < 30; k++) begin
                p = $urandom_range(0, 2);
                access(p, (p != 0) && $urandom_range(0, 1) == 1, 4'($urandom_range(1, 15)),
                       32'h1000_0000 + 32'($urandom_range(0, 15) * 4), $urandom, "rand_access");
            end
            arb_rounds(30, 1'b1, 3'b000, "rand_arb");
        end
    endtask

`ifdef MEM_ARB_PERF_EN
    task automatic test_perf();
        use_dut(0);
        do_reset();
        access(0, 1'b0, 4'h0, 32'h0040_0000, 32'h0, "perf_i1");
        access(0, 1'b0, 4'h0, 32'h0040_0004, 32'h0, "perf_i2");
        arb_rounds(1, 1'b0, 3'b110, "perf_conflict");
        access(0, 1'b0, 4'h0, 32'h0040_0008, 32'h0, "perf_i3");
        access(1, 1'b0, 4'h0, 32'h1001_0004, 32'h0, "perf_d2");
        n_chk++; if (a_perf_i !== 32'd3) $display("FAIL perf_i: got %0d want 3", a_perf_i); else n_pass++;
        n_chk++; if (a_perf_d !== 32'd2) $display("FAIL perf_d: got %0d want 2", a_perf_d); else n_pass++;
        n_chk++; if (a_perf_g !== 32'd0) $display("FAIL perf_g: got %0d want 0", a_perf_g); else n_pass++;
        n_chk++; if (a_perf_c !== 32'd1) $display("FAIL perf_conflict: got %0d want 1", a_perf_c); else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_fetch();
        test_byte_write();
        test_starve_hold();
        test_three_way();
        test_reset_wait();
        test_random();
`ifdef MEM_ARB_PERF_EN
        test_perf();
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
